// File: rtl/count_logger.sv
// Up/down counter with a history ring of pre-step count values, readable oldest-first.
// Capture runs continuously (overwrite oldest) or one-shot (freeze when full) until re-armed.
module count_logger #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter bit ONE_SHOT = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     dir,
    input  logic                     load,
    input  logic [WIDTH-1:0]         load_val,
    input  logic                     arm,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         count,
    output logic                     wrap,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     overflow,
    output logic [WIDTH-1:0]         rd_data
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      LVL_MAX = (AW+1)'(DEPTH);
    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] mem [DEPTH];

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW:0]      level_q, level_d;
    logic             full_q, full_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic [AW-1:0]    rd_idx;
    logic             capture;
    logic             we;

    // Capture is only ever suspended by a full one-shot buffer; arm/reset clear level and resume it.
    assign capture = !(ONE_SHOT && full_q);
    assign we      = en && !load && capture && !arm;

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            if (dir) begin
                count_d = count_q - WIDTH'(1);
                wrap_d  = (count_q == '0);
            end else begin
                count_d = count_q + WIDTH'(1);
                wrap_d  = (count_q == CNT_MAX);
            end
        end
    end

    always_comb begin
        wptr_d  = wptr_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        if (arm) begin
            wptr_d  = '0;
            level_d = '0;
            ovf_d   = 1'b0;
        end else if (we) begin
            wptr_d = wptr_q + AW'(1);
            if (level_q == LVL_MAX) begin
                ovf_d = 1'b1;
            end else begin
                level_d = level_q + (AW+1)'(1);
            end
        end
        full_d = (level_d == LVL_MAX);
    end

    // Oldest entry sits level slots behind the write pointer; the low AW bits suffice since
    // a full buffer (level == DEPTH) aliases to an offset of zero.
    always_comb begin
        rd_idx    = wptr_q - level_q[AW-1:0] + rd_addr;
        rd_data_d = '0;
        if ({1'b0, rd_addr} < level_q) begin
            rd_data_d = mem[rd_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            wrap_q    <= 1'b0;
            wptr_q    <= '0;
            level_q   <= '0;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            count_q   <= count_d;
            wrap_q    <= wrap_d;
            wptr_q    <= wptr_d;
            level_q   <= level_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wptr_q] <= count_q;
        end
    end

    assign count    = count_q;
    assign wrap     = wrap_q;
    assign level    = level_q;
    assign full     = full_q;
    assign overflow = ovf_q;
    assign rd_data  = rd_data_q;
endmodule
